// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl: frame-tick driven game sequencer for the dino runner.
// Sequences IDLE/RUN/DUCK/JUMP/DEAD, integrates the jump trajectory,
// and produces run animation phase, scroll offset, speed ramp and score.
// Optional build macro DINO_DOUBLE_JUMP_EN enables one mid-air jump reload.
module dino_game_ctrl #(
  parameter int POS_W      = 10,
  parameter int Y_W        = 8,
  parameter int RUN_DIV    = 6,
  parameter int JUMP_V0    = 12,
  parameter int GRAVITY    = 1,
  parameter int SPEED_INIT = 2,
  parameter int SPEED_MAX  = 8,
  parameter int SPEED_STEP = 512
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_tick,
  input  logic             start_key,
  input  logic             jump_key,
  input  logic             duck_key,
  input  logic             collision,
  output logic [2:0]       dino_pose,
  output logic [Y_W-1:0]   dino_y,
  output logic [POS_W-1:0] scroll_x,
  output logic [3:0]       speed,
  output logic [15:0]      score,
  output logic             playing
);

  // Signed trajectory width: two guard bits above the height range.
  localparam int SW     = Y_W + 2;
  localparam int AW     = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int STEP_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DUCK,
    S_JUMP,
    S_DEAD
  } state_t;

  state_t                  state_q, state_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic signed [SW-1:0]    vel_q, vel_d;
  logic [POS_W-1:0]        scroll_q, scroll_d;
  logic [3:0]              speed_q, speed_d;
  logic [15:0]             score_q, score_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [AW-1:0]           anim_q, anim_d;
  logic                    phase_q, phase_d;
  logic                    start_prev_q, start_prev_d;
  logic                    jump_prev_q, jump_prev_d;
`ifdef DINO_DOUBLE_JUMP_EN
  logic                    dj_used_q, dj_used_d;
  logic                    jump_rise;
`endif

  logic                    start_rise;
  logic                    playing_w;
  logic                    landing;
  logic signed [SW-1:0]    s_sum;

  // Clamp a signed height candidate into the unsigned Y_W output range.
  function automatic logic [Y_W-1:0] sat_y(input logic signed [SW-1:0] v);
    if (v[SW-1])             return '0;
    else if (|v[SW-2:Y_W])   return '1;
    else                     return v[Y_W-1:0];
  endfunction

  assign start_rise = start_key && !start_prev_q;
  assign playing_w  = (state_q == S_RUN) || (state_q == S_DUCK) || (state_q == S_JUMP);
`ifdef DINO_DOUBLE_JUMP_EN
  assign jump_rise  = jump_key && !jump_prev_q;
`endif

  // Next-state, trajectory, scroll/score/speed and animation updates per frame.
  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    vel_d        = vel_q;
    scroll_d     = scroll_q;
    speed_d      = speed_q;
    score_d      = score_q;
    step_d       = step_q;
    anim_d       = anim_q;
    phase_d      = phase_q;
    start_prev_d = start_prev_q;
    jump_prev_d  = jump_prev_q;
`ifdef DINO_DOUBLE_JUMP_EN
    dj_used_d    = dj_used_q;
`endif
    s_sum        = $signed({2'b00, y_q}) + vel_q;
    landing      = (s_sum[SW-1] || (s_sum == '0)) && vel_q[SW-1];

    if (frame_tick) begin
      start_prev_d = start_key;
      jump_prev_d  = jump_key;

      // Scroll, score and the speed ramp advance on every playing frame.
      if (playing_w) begin
        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
        scroll_d = scroll_q + POS_W'(speed_q);
        if (step_q == STEP_W'(SPEED_STEP - 1)) begin
          step_d = '0;
          if (speed_q < 4'(SPEED_MAX)) speed_d = speed_q + 4'd1;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      // Leg animation only runs on the ground.
      if ((state_q == S_RUN) || (state_q == S_DUCK)) begin
        if (anim_q == AW'(RUN_DIV - 1)) begin
          anim_d  = '0;
          phase_d = ~phase_q;
        end else begin
          anim_d = anim_q + AW'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_d  = S_RUN;
            score_d  = '0;
            scroll_d = '0;
            anim_d   = '0;
            phase_d  = 1'b0;
            speed_d  = 4'(SPEED_INIT);
            step_d   = '0;
          end
        end
        S_RUN, S_DUCK: begin
          if (collision) begin
            state_d = S_DEAD;
          end else if (jump_key) begin
            state_d = S_JUMP;
            vel_d   = SW'(JUMP_V0);
            y_d     = '0;
`ifdef DINO_DOUBLE_JUMP_EN
            dj_used_d = 1'b0;
`endif
          end else if (state_q == S_RUN && duck_key) begin
            state_d = S_DUCK;
          end else if (state_q == S_DUCK && !duck_key) begin
            state_d = S_RUN;
          end
        end
        S_JUMP: begin
          if (collision) begin
            state_d = S_DEAD;
`ifdef DINO_DOUBLE_JUMP_EN
          end else if (jump_rise && !dj_used_q) begin
            vel_d     = SW'(JUMP_V0);
            dj_used_d = 1'b1;
`endif
          end else if (landing) begin
            y_d     = '0;
            state_d = duck_key ? S_DUCK : S_RUN;
`ifdef DINO_DOUBLE_JUMP_EN
            dj_used_d = 1'b0;
`endif
          end else begin
            y_d   = sat_y(s_sum);
            vel_d = vel_q - SW'(GRAVITY);
          end
        end
        S_DEAD: begin
          if (start_rise) begin
            state_d = S_IDLE;
            y_d     = '0;
            vel_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      y_q          <= '0;
      vel_q        <= '0;
      scroll_q     <= '0;
      speed_q      <= 4'(SPEED_INIT);
      score_q      <= '0;
      step_q       <= '0;
      anim_q       <= '0;
      phase_q      <= 1'b0;
      start_prev_q <= 1'b0;
      jump_prev_q  <= 1'b0;
`ifdef DINO_DOUBLE_JUMP_EN
      dj_used_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      vel_q        <= vel_d;
      scroll_q     <= scroll_d;
      speed_q      <= speed_d;
      score_q      <= score_d;
      step_q       <= step_d;
      anim_q       <= anim_d;
      phase_q      <= phase_d;
      start_prev_q <= start_prev_d;
      jump_prev_q  <= jump_prev_d;
`ifdef DINO_DOUBLE_JUMP_EN
      dj_used_q    <= dj_used_d;
`endif
    end
  end

  // Sprite pose decoded from the registered state and animation phase.
  always_comb begin
    dino_pose = 3'd6;
    case (state_q)
      S_RUN:   dino_pose = phase_q ? 3'd1 : 3'd0;
      S_DUCK:  dino_pose = phase_q ? 3'd5 : 3'd4;
      S_JUMP:  dino_pose = 3'd2;
      S_DEAD:  dino_pose = 3'd3;
      default: dino_pose = 3'd6;
    endcase
  end

  assign dino_y   = y_q;
  assign scroll_x = scroll_q;
  assign speed    = speed_q;
  assign score    = score_q;
  assign playing  = playing_w;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// tb_dino_game_ctrl: scoreboard bench for dino_game_ctrl (default parameters).
module tb_dino_game_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start_key = 1'b0;
  logic        jump_key = 1'b0;
  logic        duck_key = 1'b0;
  logic        collision = 1'b0;
  logic [2:0]  dino_pose;
  logic [7:0]  dino_y;
  logic [9:0]  scroll_x;
  logic [3:0]  speed;
  logic [15:0] score;
  logic        playing;

  dino_game_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .start_key(start_key), .jump_key(jump_key), .duck_key(duck_key),
    .collision(collision), .dino_pose(dino_pose), .dino_y(dino_y),
    .scroll_x(scroll_x), .speed(speed), .score(score), .playing(playing)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string    name;
    bit [5:0] mask;
    int       pose, y, sx, sp, sc, pl;
  } exp_t;

  localparam bit [5:0] F_POSE = 6'd1, F_Y = 6'd2, F_SX = 6'd4,
                       F_SP = 6'd8, F_SC = 6'd16, F_PL = 6'd32, F_ALL = 6'd63;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic tick_dly = 1'b0;
  logic force_chk = 1'b0;

  task automatic cmp(input string nm, input string f, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s got=%0d expected=%0d", nm, f, act, req);
    end
  endtask

  // Monitor: outputs are presented the cycle after a frame_tick (or on demand).
  always @(posedge Clk) tick_dly <= frame_tick;

  always @(negedge Clk) begin
    if (tick_dly || force_chk) begin
      if (exp_q.size() == 0) begin
        cmp("monitor", "queue_empty", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.mask[0]) cmp(mon_e.name, "pose",    int'(dino_pose), mon_e.pose);
        if (mon_e.mask[1]) cmp(mon_e.name, "dino_y",  int'(dino_y),    mon_e.y);
        if (mon_e.mask[2]) cmp(mon_e.name, "scroll",  int'(scroll_x),  mon_e.sx);
        if (mon_e.mask[3]) cmp(mon_e.name, "speed",   int'(speed),     mon_e.sp);
        if (mon_e.mask[4]) cmp(mon_e.name, "score",   int'(score),     mon_e.sc);
        if (mon_e.mask[5]) cmp(mon_e.name, "playing", int'(playing),   mon_e.pl);
      end
    end
  end

  function automatic exp_t mk(input string nm, input bit [5:0] m, input int pose, y,
                              sx, sp, sc, pl);
    exp_t e;
    e.name = nm; e.mask = m; e.pose = pose; e.y = y;
    e.sx = sx; e.sp = sp; e.sc = sc; e.pl = pl;
    return e;
  endfunction

  // One frame: push expectation, pulse frame_tick for a single cycle.
  task automatic step(input string nm, input bit [5:0] m, input int pose, y, sx, sp,
                      sc, pl);
    @(negedge Clk);
    exp_q.push_back(mk(nm, m, pose, y, sx, sp, sc, pl));
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  // Check outputs at the next falling edge without a frame tick.
  task automatic check_now(input string nm, input bit [5:0] m, input int pose, y, sx,
                           sp, sc, pl);
    exp_q.push_back(mk(nm, m, pose, y, sx, sp, sc, pl));
    force_chk = 1'b1;
    @(negedge Clk);
    #1 force_chk = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int traj[25];
    int dj[4];
    int sx, sp, sc, pose;
    traj = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
             77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};
`ifdef DINO_DOUBLE_JUMP_EN
    dj = '{78, 90, 101, 111};
`else
    dj = '{78, 77, 75, 72};
`endif

    // Reset state
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b0;
    check_now("reset", F_ALL, 6, 0, 0, 2, 0, 0);

    // Start and run animation / scroll
    start_key = 1'b1;
    step("start", F_ALL, 0, 0, 0, 2, 0, 1);
    start_key = 1'b0;
    for (int k = 1; k <= 12; k++)
      step("run", F_ALL, (k >= 6 && k < 12) ? 1 : 0, 0, 2 * k, 2, k, 1);

    // Full jump trajectory with landing back into RUN
    jump_key = 1'b1;
    step("jump_launch", F_ALL, 2, 0, 26, 2, 13, 1);
    jump_key = 1'b0;
    for (int k = 1; k <= 25; k++)
      step("jump_traj", F_POSE | F_Y | F_SX | F_SC | F_PL, (k < 25) ? 2 : 0,
           traj[k-1], 26 + 2 * k, 2, 13 + k, 1);

    // Second jump probing the mid-air reload at the apex
    jump_key = 1'b1;
    step("dj_launch", F_POSE | F_Y, 2, 0, 0, 0, 0, 1);
    jump_key = 1'b0;
    for (int k = 1; k <= 12; k++)
      step("dj_rise", F_Y, 0, traj[k-1], 0, 0, 0, 0);
    for (int k = 13; k <= 16; k++) begin
      jump_key = (k == 13 || k == 15);
      step("dj_probe", F_Y | F_POSE, 2, dj[k-13], 0, 0, 0, 0);
    end
    jump_key = 1'b0;

    // Reset asserted mid-jump, checked before the next rising edge
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1 check_now("reset_mid_jump", F_ALL, 6, 0, 0, 2, 0, 0);
    @(posedge Clk);
    #2 Reset = 1'b0;

    // Long run: scroll wrap, speed ramp and saturation, score per tick
    start_key = 1'b1;
    step("start_long", F_ALL, 0, 0, 0, 2, 0, 1);
    start_key = 1'b0;
    sx = 0; sp = 2; sc = 0;
    for (int k = 1; k <= 3600; k++) begin
      sx = (sx + sp) % 1024;
      sc = sc + 1;
      if ((k % 512) == 0 && sp < 8) sp = sp + 1;
      pose = ((k / 6) % 2 == 1) ? 1 : 0;
      step((k == 512) ? "wrap_speed3" : "run_model", F_ALL, pose, 0, sx, sp, sc, 1);
    end

    // Collision beats jump; held start does not restart
    sx = (sx + 8) % 1024;
    collision = 1'b1; jump_key = 1'b1; start_key = 1'b1;
    step("collide", F_ALL, 3, 0, sx, 8, 3601, 0);
    collision = 1'b0; jump_key = 1'b0;
    for (int k = 0; k < 3; k++)
      step("dead_hold", F_ALL, 3, 0, sx, 8, 3601, 0);
    start_key = 1'b0;
    step("dead_release", F_ALL, 3, 0, sx, 8, 3601, 0);
    start_key = 1'b1;
    step("dead_to_idle", F_ALL, 6, 0, sx, 8, 3601, 0);
    start_key = 1'b0;
    step("idle_wait", F_ALL, 6, 0, sx, 8, 3601, 0);
    start_key = 1'b1;
    step("restart", F_ALL, 0, 0, 0, 2, 0, 1);
    start_key = 1'b0;

    // Duck animation, back to RUN, then collision priority in DUCK
    duck_key = 1'b1;
    for (int k = 1; k <= 6; k++)
      step("duck", F_ALL, (k == 6) ? 5 : 4, 0, 2 * k, 2, k, 1);
    duck_key = 1'b0;
    step("unduck", F_ALL, 1, 0, 14, 2, 7, 1);
    duck_key = 1'b1;
    step("duck_again", F_POSE | F_PL, 5, 0, 0, 0, 0, 1);
    collision = 1'b1; jump_key = 1'b1;
    step("duck_collide", F_ALL, 3, 0, 18, 2, 9, 0);
    collision = 1'b0; jump_key = 1'b0; duck_key = 1'b0;

    @(negedge Clk);
    @(negedge Clk);
    cmp("scoreboard", "leftover", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dino_game_ctrl.md
Name: dino_game_ctrl

Overview:
Parametrised successor to the dino game controller. It sequences idle/run/duck/jump/dead and computes the jump trajectory internally, so no external jump-end strobe is needed. It also produces run-animation phase, scroll position, speed ramp and score. It sits between the keyboard/collision logic and the sprite/background renderers, and all game state advances only on the one-cycle frame_tick.

Parameters:
POS_W, 10, width of scroll_x; wraps modulo 2^POS_W
Y_W, 8, width of dino_y (height above ground, pixels)
RUN_DIV, 6, frame_ticks per run/duck animation phase
JUMP_V0, 12, initial upward velocity (pixels/frame)
GRAVITY, 1, velocity decrement per frame
SPEED_INIT, 2, scroll speed at game start (pixels/frame)
SPEED_MAX, 8, speed saturation value (≤15)
SPEED_STEP, 512, playing frames between +1 speed increments

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
start_key  in  1  level; start/restart request
jump_key  in  1  level; jump request
duck_key  in  1  level; duck request
collision  in  1  level; dino/obstacle overlap, sampled on frame_tick
dino_pose  out  3  0 run_a, 1 run_b, 2 jump, 3 dead, 4 duck_a, 5 duck_b, 6 idle
dino_y  out  Y_W  dino height above ground
scroll_x  out  POS_W  background scroll offset
speed  out  4  current scroll speed
score  out  16  frames survived, saturating
playing  out  1  high in RUN/DUCK/JUMP

Behaviour:
- Reset (async) value of every output and register: state IDLE, dino_pose=6, dino_y=0, velocity=0, scroll_x=0, speed=SPEED_INIT, score=0, playing=0, anim counter=0, anim phase=0, key-history registers=0.
- All registers update only on a Clk edge with frame_tick=1. With frame_tick=0, everything holds. Outputs are registered and decoded from state, so there is 0-cycle latency from the state change.
- Key edges: the previous start_key and jump_key values are registered on each frame_tick. A rise means the current value is 1 and the stored previous value is 0.
- Transition priority per frame, highest first: collision, jump, duck.
- IDLE: on a start_key rise, go to RUN and clear score, scroll_x, anim counter and anim phase; set speed=SPEED_INIT.
- RUN:
  - collision → DEAD
  - jump_key=1 → JUMP (load velocity=JUMP_V0, dino_y=0)
  - duck_key=1 → DUCK
  - otherwise stay in RUN
- DUCK: collision → DEAD; jump_key=1 → JUMP; duck_key=0 → RUN.
- JUMP, each frame:
  - compute s = dino_y + velocity using signed arithmetic of width Y_W+2.
  - If s ≤ 0 and velocity < 0: set dino_y=0 and exit to DUCK if duck_key=1, otherwise to RUN.
  - Otherwise set dino_y = s, saturated to 2^Y_W−1, and velocity = velocity − GRAVITY.
  - Collision → DEAD takes priority over landing.
- DEAD: scroll_x, score, speed and dino_y freeze. On a start_key rise, go to IDLE with dino_y cleared. The rise requirement stops a held key from auto-restarting.
- While playing, each frame:
  - score += 1, saturating at 16'hFFFF.
  - scroll_x += speed, wrapping.
  - the step counter increments; on reaching SPEED_STEP it clears and speed += 1, saturating at SPEED_MAX.
- Animation: in RUN and DUCK the anim counter counts frames. At RUN_DIV−1 it wraps to 0 and the anim phase toggles. It is frozen in other states.
- Pose decode:
  - RUN: phase 0 → 0, phase 1 → 1
  - DUCK: phase 0 → 4, phase 1 → 5
  - JUMP → 2
  - DEAD → 3
  - IDLE → 6
- Reset mid-jump: immediate return to the reset values; no partial trajectory is retained.

Optional Feature:
DINO_DOUBLE_JUMP_EN: when defined, a jump_key rise while in JUMP reloads velocity=JUMP_V0 without changing dino_y. This is allowed once per airtime; a one-bit flag clears on landing. When undefined, jump_key is ignored in JUMP.

Test Plan:
- Reset, then pulse start_key on a tick → RUN, pose toggles 0→1 after 6 ticks and back to 0 after 12; scroll_x=8 after 4 ticks.
- In RUN, hold jump_key for 1 tick and then release → dino_y reads 12, 23, 33 … peaks at 78 on tick 12, returns to 0 on tick 25 and re-enters RUN (pose 0/1).
- Collision asserted on the same tick as jump_key in RUN → DEAD, pose=3, score and scroll_x frozen. A held start_key does not restart; release then press → IDLE, pose=6.
- Play 512 frames → speed 2→3; continue → speed saturates at 8, and score increments by exactly 1 per tick.
- Wrap check: with speed=2 and scroll_x=1022, one tick → scroll_x=0. Assert Reset mid-jump → dino_y=0 and pose=6 before the next Clk edge.
- With DINO_DOUBLE_JUMP_EN defined, a second jump_key rise at y=78 → velocity reloads to 12, and a third rise is ignored. Without the macro, the second rise is ignored.
